// File: rtl/sine_thermo_gen.sv
// -----------------------------------------------------------------------------
// sine_thermo_gen
//
// Thermometer-coded sine generator for the digital current-generator path.
// An up/down phase counter sweeps ZERO -> MAX -> ZERO at a programmable tick
// rate. A polarity sign flips at the end of every half-period. The phase is
// compared against a run-time programmable table of per-cell thresholds, and
// the result drives N_CELLS unary current cells.
//
// Parameters
//   PHASE_W  phase counter width; ZERO = 1, MAX = 2^PHASE_W - 2
//   N_CELLS  number of thermometer cells / thresholds
//   DIV_W    tick-divider width
//   ACT_LOW  1: sine_out active-low (cell on = 0); 0: active-high
//   CADDR_W  threshold address width (>= clog2(N_CELLS))
//
// Ports
//   clk        in   clock; all state changes on the rising edge
//   rst        in   synchronous, active-high reset
//   en         in   run request, level-sensitive
//   div        in   tick period minus one, latched on IDLE -> RISE
//   cfg_we     in   threshold write strobe
//   cfg_addr   in   threshold index; out-of-range indices are ignored
//   cfg_data   in   threshold value
//   sine_out   out  registered cell drive
//   pos        out  phase counter
//   sign       out  polarity of the current half-period (registered)
//   at_max     out  pos == MAX (combinational)
//   at_zero    out  pos == ZERO (combinational)
//   half_done  out  one-cycle pulse after the edge where pos returns to ZERO
//   busy       out  sweep in progress (state != IDLE)
// -----------------------------------------------------------------------------
module sine_thermo_gen #(
  parameter int PHASE_W = 7,
  parameter int N_CELLS = 18,
  parameter int DIV_W   = 8,
  parameter bit ACT_LOW = 1'b1,
  parameter int CADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [DIV_W-1:0]   div,
  input  logic               cfg_we,
  input  logic [CADDR_W-1:0] cfg_addr,
  input  logic [PHASE_W-1:0] cfg_data,
  output logic [N_CELLS-1:0] sine_out,
  output logic [PHASE_W-1:0] pos,
  output logic               sign,
  output logic               at_max,
  output logic               at_zero,
  output logic               half_done,
  output logic               busy
);

  // Codes 0 and all-ones are never reached by the counter. All-ones is the
  // "never on" threshold, so a cell with that threshold stays off.
  localparam logic [PHASE_W-1:0] ZERO = PHASE_W'(1);
  localparam logic [PHASE_W-1:0] MAX  = {{(PHASE_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2
  } state_e;

  state_e             state, state_nxt;
  logic [PHASE_W-1:0] pos_nxt;
  logic [DIV_W-1:0]   cnt, cnt_nxt;
  logic [DIV_W-1:0]   div_q, div_q_nxt;
  logic               sign_nxt;
  logic               half_done_nxt;
  logic               tick;

  // ---------------------------------------------------------------------------
  // Sequencer: next-state and datapath updates
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_nxt     = state;
    pos_nxt       = pos;
    cnt_nxt       = cnt;
    div_q_nxt     = div_q;
    sign_nxt      = sign;
    half_done_nxt = 1'b0;

    // The divider counts 0..div_q. A tick fires on the last count, so ticks
    // are div_q + 1 cycles apart. With div_q = 0 there is a tick every cycle.
    tick = (cnt >= div_q);

    case (state)
      IDLE: begin
        pos_nxt = ZERO;
        cnt_nxt = '0;
        if (en) begin
          div_q_nxt = div;
          state_nxt = RISE;
        end
      end

      RISE: begin
        cnt_nxt = tick ? '0 : cnt + 1'b1;
        if (tick) begin
          pos_nxt = pos + 1'b1;
          // Turn around on the same tick that reaches MAX. MAX is then held
          // for only one tick period, with no extra stall cycle.
          if (pos_nxt == MAX) begin
            state_nxt = FALL;
          end
        end
      end

      FALL: begin
        cnt_nxt = tick ? '0 : cnt + 1'b1;
        if (tick) begin
          pos_nxt = pos - 1'b1;
          // en is only looked at here. Dropping it mid-sweep lets the current
          // half-period finish, so the stop is graceful.
          if (pos_nxt == ZERO) begin
            half_done_nxt = 1'b1;
            if (en) begin
              sign_nxt  = ~sign;
              state_nxt = RISE;
            end else begin
              sign_nxt  = 1'b0;
              state_nxt = IDLE;
            end
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        pos_nxt   = ZERO;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge.
    if (rst) begin
      state     <= IDLE;
      pos       <= ZERO;
      cnt       <= '0;
      div_q     <= '0;
      sign      <= 1'b0;
      half_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      pos       <= pos_nxt;
      cnt       <= cnt_nxt;
      div_q     <= div_q_nxt;
      sign      <= sign_nxt;
      half_done <= half_done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Threshold table: writable in any state
  // ---------------------------------------------------------------------------
  logic [PHASE_W-1:0] thr [N_CELLS];
  logic               addr_ok;

  assign addr_ok = (int'(cfg_addr) < N_CELLS);

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this small register table is reset on purpose. All-ones is the
      // "cell off" code, so the cell drive is safe right after reset. Reset
      // also wins over a write in the same cycle.
      for (int i = 0; i < N_CELLS; i++) begin
        thr[i] <= '1;
      end
    end else if (cfg_we && addr_ok) begin
      thr[cfg_addr] <= cfg_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Thermometer compare and registered cell drive
  // ---------------------------------------------------------------------------
  logic [N_CELLS-1:0] cell_on;

  always_comb begin
    cell_on = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      cell_on[i] = (pos >= thr[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sine_out <= {N_CELLS{ACT_LOW}};
    end else begin
      sine_out <= cell_on ^ {N_CELLS{ACT_LOW}};
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational status
  // ---------------------------------------------------------------------------
  assign at_max  = (pos == MAX);
  assign at_zero = (pos == ZERO);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_sine_thermo_gen.sv
// -----------------------------------------------------------------------------
// tb_sine_thermo_gen
//
// Scoreboard bench for sine_thermo_gen. Stimulus tasks push expected values,
// tagged with the cycle they apply to, into a queue. Expected half_done pulse
// cycles go into a second queue. A negedge monitor pops and compares: per-cycle
// items when their cycle arrives, and pulse items whenever the DUT raises
// half_done. The cycle number is the count of rising edges seen so far.
// -----------------------------------------------------------------------------
module tb_sine_thermo_gen;

  localparam int PHASE_W = 7;
  localparam int N_CELLS = 18;
  localparam int DIV_W   = 8;
  localparam bit ACT_LOW = 1'b1;
  localparam int CADDR_W = 5;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b0;
  logic [DIV_W-1:0]   div = '0;
  logic               cfg_we = 1'b1;
  logic [CADDR_W-1:0] cfg_addr = '0;
  logic [PHASE_W-1:0] cfg_data = '0;
  logic [N_CELLS-1:0] sine_out;
  logic [PHASE_W-1:0] pos;
  logic               sign, at_max, at_zero, half_done, busy;

  sine_thermo_gen #(
    .PHASE_W(PHASE_W), .N_CELLS(N_CELLS), .DIV_W(DIV_W),
    .ACT_LOW(ACT_LOW), .CADDR_W(CADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .div(div),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .sine_out(sine_out), .pos(pos), .sign(sign), .at_max(at_max),
    .at_zero(at_zero), .half_done(half_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {S_POS, S_SIGN, S_BUSY, S_ATMAX, S_ATZERO, S_HALF, S_SINE} sig_e;
  typedef struct {
    int          cyc;
    sig_e        sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   hq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [31:0] ALL_OFF = 32'h3FFFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, expv);
    end
  endtask

  function automatic string sig_name(sig_e s);
    case (s)
      S_POS:    return "pos";
      S_SIGN:   return "sign";
      S_BUSY:   return "busy";
      S_ATMAX:  return "at_max";
      S_ATZERO: return "at_zero";
      S_HALF:   return "half_done";
      default:  return "sine_out";
    endcase
  endfunction

  function automatic logic [31:0] sample(sig_e s);
    case (s)
      S_POS:    return 32'(pos);
      S_SIGN:   return 32'(sign);
      S_BUSY:   return 32'(busy);
      S_ATMAX:  return 32'(at_max);
      S_ATZERO: return 32'(at_zero);
      S_HALF:   return 32'(half_done);
      default:  return 32'(sine_out);
    endcase
  endfunction

  function automatic void expect_at(int c, sig_e s, logic [31:0] v);
    exp_t e;
    e.cyc = c;
    e.sel = s;
    e.val = v;
    sb.push_back(e);
  endfunction

  // Closed-form phase t cycles after the start edge, for a tick period of per
  // cycles: up 125 ticks to 126, then down 125 ticks to 1.
  function automatic int exp_pos(int t, int per);
    int m;
    m = t / per;
    if (m <= 125) return 1 + m;
    return 251 - m;
  endfunction

  // Active-low drive with thr[i] = 7*i + 1 at phase p.
  function automatic logic [31:0] exp_sine(int p);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < N_CELLS; i++) v[i] = !((7 * i + 1) <= p);
    return v;
  endfunction

  // Monitor
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check(sig_name(sb[i].sel), sample(sb[i].sel), sb[i].val);
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        check({sig_name(sb[i].sel), "_missed"}, 32'(cyc), 32'(sb[i].cyc));
        sb.delete(i);
      end
    end
    if (half_done === 1'b1) begin
      if (hq.size() == 0) check("half_done_unexpected", 32'(half_done), 32'd0);
      else                check("half_done_cycle", 32'(cyc), 32'(hq.pop_front()));
    end else if (hq.size() > 0 && hq[0] < cyc) begin
      check("half_done_missing", 32'(cyc), 32'(hq.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k0, k1, k2, k3, k4, w0, wa;

    // Reset for three edges with a write pending: the write must not land.
    rst = 1'b1; cfg_we = 1'b1; cfg_addr = '0; cfg_data = '0; en = 1'b0;
    repeat (3) tick();
    expect_at(3, S_POS, 1);
    expect_at(3, S_BUSY, 0);
    expect_at(3, S_SIGN, 0);
    expect_at(3, S_SINE, ALL_OFF);
    expect_at(3, S_ATZERO, 1);
    expect_at(3, S_ATMAX, 0);
    expect_at(3, S_HALF, 0);
    expect_at(4, S_SINE, ALL_OFF);
    expect_at(5, S_SINE, ALL_OFF);
    rst = 1'b0; cfg_we = 1'b0;
    wait_until(6);

    // Full sweep with div = 0 and en held, then a second sweep with en dropped at pos 60.
    k0 = cyc + 1;
    for (int j = 0; j <= 250; j++) expect_at(k0 + j, S_POS, exp_pos(j, 1));
    expect_at(k0, S_BUSY, 1);
    expect_at(k0 + 124, S_ATMAX, 0);
    expect_at(k0 + 125, S_ATMAX, 1);
    expect_at(k0 + 126, S_ATMAX, 0);
    expect_at(k0 + 126, S_SINE, ALL_OFF);
    expect_at(k0 + 249, S_HALF, 0);
    expect_at(k0 + 249, S_SIGN, 0);
    expect_at(k0 + 250, S_HALF, 1);
    expect_at(k0 + 250, S_SIGN, 1);
    expect_at(k0 + 250, S_BUSY, 1);
    expect_at(k0 + 250, S_ATZERO, 1);
    expect_at(k0 + 251, S_HALF, 0);
    expect_at(k0 + 251, S_SIGN, 1);
    hq.push_back(k0 + 250);
    k1 = k0 + 250;
    for (int j = 1; j <= 250; j++) expect_at(k1 + j, S_POS, exp_pos(j, 1));
    expect_at(k1 + 100, S_SIGN, 1);
    expect_at(k1 + 250, S_HALF, 1);
    expect_at(k1 + 250, S_SIGN, 0);
    expect_at(k1 + 250, S_BUSY, 0);
    expect_at(k1 + 251, S_POS, 1);
    expect_at(k1 + 251, S_BUSY, 0);
    expect_at(k1 + 251, S_HALF, 0);
    hq.push_back(k1 + 250);
    en = 1'b1; div = 8'd0;
    wait_until(k1 + 59);
    en = 1'b0;
    wait_until(k1 + 252);

    // Divider 3: ticks 4 cycles apart; a mid-sweep change of div is ignored.
    k2 = cyc + 1;
    for (int t = 0; t <= 40; t++) expect_at(k2 + t, S_POS, exp_pos(t, 4));
    for (int t = 496; t <= 508; t++) expect_at(k2 + t, S_POS, exp_pos(t, 4));
    expect_at(k2 + 499, S_ATMAX, 0);
    expect_at(k2 + 500, S_ATMAX, 1);
    expect_at(k2 + 503, S_ATMAX, 1);
    expect_at(k2 + 504, S_ATMAX, 0);
    expect_at(k2 + 999, S_POS, 2);
    expect_at(k2 + 999, S_BUSY, 1);
    expect_at(k2 + 1000, S_POS, 1);
    expect_at(k2 + 1000, S_BUSY, 0);
    hq.push_back(k2 + 1000);
    en = 1'b1; div = 8'd3;
    wait_until(k2 + 10);
    div = 8'd0;
    wait_until(k2 + 20);
    en = 1'b0;
    wait_until(k2 + 1002);

    // Program thresholds 7*i+1 from IDLE (pos = 1); the first write shows one edge later.
    w0 = cyc + 1;
    expect_at(w0, S_SINE, ALL_OFF);
    expect_at(w0 + 1, S_SINE, 32'h3FFFE);
    for (int i = 0; i < N_CELLS; i++) begin
      cfg_we = 1'b1; cfg_addr = CADDR_W'(i); cfg_data = PHASE_W'(7 * i + 1);
      tick();
    end
    wa = cyc + 1;
    expect_at(wa + 1, S_SINE, 32'h3FFFE);
    expect_at(wa + 2, S_SINE, 32'h3FFFE);
    cfg_addr = 5'd20; cfg_data = '0;
    tick();
    cfg_we = 1'b0;
    wait_until(wa + 2);

    // One sweep with the programmed table; sine_out lags pos by one edge.
    k3 = cyc + 1;
    for (int j = 1; j <= 251; j++) expect_at(k3 + j, S_SINE, exp_sine(exp_pos(j - 1, 1)));
    hq.push_back(k3 + 250);
    en = 1'b1; div = 8'd0;
    tick();
    en = 1'b0;
    wait_until(k3 + 253);

    // Reset at pos 90 while falling: no half_done, table back to all-ones.
    k4 = cyc + 1;
    expect_at(k4 + 161, S_POS, 90);
    expect_at(k4 + 161, S_ATMAX, 0);
    expect_at(k4 + 162, S_POS, 1);
    expect_at(k4 + 162, S_BUSY, 0);
    expect_at(k4 + 162, S_HALF, 0);
    expect_at(k4 + 162, S_SIGN, 0);
    expect_at(k4 + 162, S_ATZERO, 1);
    expect_at(k4 + 162, S_SINE, ALL_OFF);
    expect_at(k4 + 163, S_SINE, ALL_OFF);
    expect_at(k4 + 163, S_BUSY, 0);
    expect_at(k4 + 163, S_POS, 1);
    expect_at(k4 + 164, S_SINE, ALL_OFF);
    expect_at(k4 + 164, S_HALF, 0);
    en = 1'b1; div = 8'd0;
    wait_until(k4 + 161);
    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0;
    wait_until(k4 + 170);

    foreach (sb[i]) check({sig_name(sb[i].sel), "_unchecked"}, 32'(cyc), 32'(sb[i].cyc));
    foreach (hq[i]) check("half_done_unchecked", 32'(cyc), 32'(hq[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
